// File: rtl/bus_stream_writer.sv
// bus_stream_writer: a bus-written sample FIFO that drains to a ready/valid
// stream, paced by a programmable tick divider.
//
// Ports:
//   clk, reset          single clock, asynchronous active-low reset
//   chipselect, address, write, write_data, read, read_data
//                       register bus; read_data is registered
//   sink_valid, sink_data, sink_ready
//                       output sample stream
//   irq                 registered low-watermark level interrupt
//
// Register map:
//   0  W  push sample (write_data[DATA_SIZE-1:0]); reads as 0
//   1  RW CTRL   write: bit0 enable, bit1 irq_en, bit2 clear flags, bit3 flush
//                read : level at [16+], bit4 underrun, bit3 overflow,
//                       bit2 full, bit1 empty, bit0 enable
//   2  RW DIVIDER (16 bit)
//   3  RW WATERMARK (ADDR_WIDTH+1 bit)
//
// Output FSM:
//   state     | meaning
//   IDLE      | output disabled
//   WAIT_TICK | waiting for a pacing tick to present the FIFO head
//   PRESENT   | sample held on sink until the consumer accepts it
module bus_stream_writer #(
  parameter int DATA_SIZE  = 28,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 write,
  input  logic [31:0]          write_data,
  input  logic                 read,
  output logic [31:0]          read_data,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  input  logic                 sink_ready,
  output logic                 irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TICK, S_PRESENT} state_t;

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_next;
  logic                  enable, irq_en;
  logic [15:0]           divider, tick_cnt;
  logic [ADDR_WIDTH:0]   watermark, level;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [DATA_SIZE-1:0]  data_q;
  logic                  overflow, underrun;
  logic                  bus_wr, push_req, ctrl_wr, flush, clear_flags;
  logic                  push_ok, pop, full, empty, tick;
  logic                  overflow_set, underrun_set;
  logic [31:0]           rd_mux;

  // Upper write_data bits are not used by any register.
  logic unused_bits;
  assign unused_bits = &{1'b0, write_data};

  assign bus_wr       = chipselect && write;
  assign push_req     = bus_wr && (address == 2'd0);
  assign ctrl_wr      = bus_wr && (address == 2'd1);
  assign flush        = ctrl_wr && write_data[3];
  assign clear_flags  = ctrl_wr && write_data[2];
  assign full         = (level == FULL_LEVEL);
  assign empty        = (level == '0);
  assign push_ok      = push_req && !flush && !full;
  assign pop          = sink_valid && sink_ready && !flush;
  // >= keeps pacing sane if DIVIDER is lowered below the running count.
  assign tick         = enable && (tick_cnt >= divider);
  assign overflow_set = push_req && !flush && full;
  assign underrun_set = (state == S_WAIT_TICK) && tick && empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      divider   <= '0;
      watermark <= '0;
    end else if (bus_wr) begin
      case (address)
        2'd1: begin
          enable <= write_data[0];
          irq_en <= write_data[1];
        end
        2'd2:    divider   <= write_data[15:0];
        2'd3:    watermark <= write_data[ADDR_WIDTH:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       tick_cnt <= '0;
    else if (!enable) tick_cnt <= '0;
    else if (tick)    tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
        2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= write_data[DATA_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else if (clear_flags) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (overflow_set) overflow <= 1'b1;
      if (underrun_set) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = S_IDLE;
    end else if (flush) begin
      state_next = S_WAIT_TICK;
    end else begin
      case (state)
        S_IDLE:      state_next = S_WAIT_TICK;
        S_WAIT_TICK: if (tick && !empty) state_next = S_PRESENT;
        S_PRESENT:   if (sink_ready) state_next = S_WAIT_TICK;
        default:     state_next = S_IDLE;
      endcase
    end
  end

  // Capture the head as the sample is presented so it stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else if ((state == S_WAIT_TICK) && (state_next == S_PRESENT)) data_q <= mem[rd_ptr];
  end

  always_comb begin
    sink_valid = (state == S_PRESENT);
    sink_data  = sink_valid ? data_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= irq_en && enable && (level <= watermark);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd1: begin
        rd_mux[16 +: ADDR_WIDTH + 1] = level;
        rd_mux[4] = underrun;
        rd_mux[3] = overflow;
        rd_mux[2] = full;
        rd_mux[1] = empty;
        rd_mux[0] = enable;
      end
      2'd2:    rd_mux = 32'(divider);
      2'd3:    rd_mux = 32'(watermark);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  read_data <= '0;
    else if (chipselect && read) read_data <= rd_mux;
  end

endmodule

// File: tb/tb_bus_stream_writer.sv
// Self-checking bench for bus_stream_writer: a queue holds the samples the
// FIFO should contain; the stream monitor pops and compares on handshake.
module tb_bus_stream_writer;

  localparam int DATA_SIZE = 28;
  localparam int DEPTH     = 64;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 chipselect = 1'b0;
  logic [1:0]           address = '0;
  logic                 write = 1'b0;
  logic [31:0]          write_data = '0;
  logic                 read = 1'b0;
  logic [31:0]          read_data;
  logic                 sink_valid;
  logic [DATA_SIZE-1:0] sink_data;
  logic                 sink_ready = 1'b0;
  logic                 irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pop = 0;
  int last_hs = -1;
  bit gap_on = 1'b0;
  logic [DATA_SIZE-1:0] exp_q[$];

  bus_stream_writer #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .write_data(write_data), .read(read), .read_data(read_data),
    .sink_valid(sink_valid), .sink_data(sink_data), .sink_ready(sink_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream monitor: sampled mid-cycle, sees the handshake the next edge takes.
  always @(negedge clk) begin
    if (sink_valid === 1'b1 && sink_ready === 1'b1) begin
      n_pop++;
      check_val("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val("sink_data", 32'(sink_data), 32'(exp_q.pop_front()));
      if (gap_on && last_hs >= 0) check_val("tick_gap", 32'(cyc - last_hs), 32'd4);
      last_hs = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; write_data = d; chipselect = 1'b1; write = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    step();
    chipselect = 1'b0; read = 1'b0;
    d = read_data;
  endtask

  task automatic push(input logic [31:0] v);
    if (exp_q.size() < DEPTH) exp_q.push_back(v[DATA_SIZE-1:0]);
    bus_write(2'd0, v);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (sink_valid !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check_val("wait_valid", 32'(sink_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int np;
    bit e;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_read_data", read_data, 32'd0);
    check_val("rst_sink_valid", 32'(sink_valid), 32'd0);
    check_val("rst_sink_data", 32'(sink_data), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    step();
    bus_read(2'd1, rd); check_val("status_after_reset", rd, 32'h0000_0002);

    // three samples, DIVIDER=3, consumer always ready
    sink_ready = 1'b1;
    push(32'h1); push(32'h2); push(32'h3);
    bus_write(2'd2, 32'd3);
    bus_read(2'd2, rd); check_val("divider_rb", rd, 32'd3);
    bus_read(2'd0, rd); check_val("addr0_read", rd, 32'd0);
    np = n_pop; gap_on = 1'b1; last_hs = -1;
    bus_write(2'd1, 32'h1);
    wait_drain(80);
    check_val("pops_t1", 32'(n_pop - np), 32'd3);
    repeat (6) step();
    bus_read(2'd1, rd); check_val("status_underrun", rd, 32'h0000_0013);
    gap_on = 1'b0;
    bus_write(2'd1, 32'h4);

    // overfill while disabled, then drain in order
    bus_write(2'd1, 32'h8);
    for (int i = 0; i < DEPTH + 2; i++) push(32'h100 + 32'(i));
    bus_read(2'd1, rd); check_val("status_full", rd, (32'(DEPTH) << 16) | 32'hC);
    bus_write(2'd2, 32'd0);
    np = n_pop;
    bus_write(2'd1, 32'h1);
    wait_drain(DEPTH * 4 + 50);
    repeat (5) step();
    check_val("pops_t2", 32'(n_pop - np), 32'(DEPTH));
    bus_read(2'd1, rd); check_val("status_drained", rd, 32'h0000_001B);
    bus_write(2'd1, 32'h4);

    // back-pressure hold
    sink_ready = 1'b0;
    push(32'hA); push(32'hB);
    bus_write(2'd1, 32'h1);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", 32'(sink_valid), 32'd1);
      check_val("hold_data", 32'(sink_data), 32'(exp_q[0]));
      step();
    end
    np = n_pop;
    sink_ready = 1'b1;
    step();
    sink_ready = 1'b0;
    repeat (2) step();
    check_val("single_pop", 32'(n_pop - np), 32'd1);
    bus_read(2'd1, rd); check_val("status_level1", rd, 32'h0001_0001);
    wait_valid(10);
    check_val("second_head", 32'(sink_data), 32'(exp_q[0]));

    // reset while presenting
    reset = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(sink_valid), 32'd0);
    check_val("mid_rst_data", 32'(sink_data), 32'd0);
    exp_q.delete();
    repeat (2) step();
    reset = 1'b1;
    step();
    bus_read(2'd1, rd); check_val("status_post_rst", rd, 32'h0000_0002);
    bus_read(2'd2, rd); check_val("divider_post_rst", rd, 32'd0);

    // low-watermark interrupt
    sink_ready = 1'b1;
    push(32'h11); push(32'h12); push(32'h13); push(32'h14);
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, rd); check_val("watermark_rb", rd, 32'd2);
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h3);
    for (int i = 0; i < 30; i++) begin
      e = (exp_q.size() <= 2);
      step();
      check_val("irq", 32'(irq), 32'(e));
    end
    check_val("irq_drain", 32'(exp_q.size()), 32'd0);
    bus_write(2'd1, 32'h4);

    // flush at level 5 while presenting
    bus_write(2'd2, 32'd0);
    sink_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h21 + 32'(i));
    bus_write(2'd1, 32'h1);
    wait_valid(20);
    bus_read(2'd1, rd); check_val("status_level5", rd, 32'h0005_0001);
    bus_write(2'd2, 32'd1000);
    exp_q.delete();
    bus_write(2'd1, 32'h9);
    check_val("flush_valid", 32'(sink_valid), 32'd0);
    bus_read(2'd1, rd); check_val("status_flushed", rd, 32'h0000_0003);

    // clear beats a same-cycle underrun
    bus_write(2'd2, 32'd0);
    repeat (3) step();
    bus_read(2'd1, rd); check_val("status_ur_set", rd, 32'h0000_0013);
    bus_write(2'd1, 32'h5);
    bus_read(2'd1, rd); check_val("clear_priority", rd, 32'h0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
